// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB bus arbiter and its round-robin core.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam int ID_W            = 2;
  localparam int DEFAULT_TIMEOUT = 16;

  // Index width for an n-entry requester vector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: combinational next winner searched from pointer+1,
// plus the registered pointer that remembers the last granted index.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             load,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    // NOTE: every output of this block gets a default before the search, so no path leaves one unassigned and no latch is inferred.
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(ptr) + k) % N);
      end
    end
  end

  assign onehot = found ? (N'(1) << idx) : '0;

  // Pointer starts at the last index so requester 0 has top priority after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registered state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      ptr <= IDX_W'(N - 1);
    end else if (load) begin
      ptr <= idx;
    end
  end

endmodule

// File: rtl/apb_bus_arbiter.sv
// Round-robin APB master sequencer: shares one APB bus between NUM_REQ
// requesters, honours wait states, and aborts hung accesses after TIMEOUT cycles.
module apb_bus_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ID_W-1:0]   req_id,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      sel,
  output logic                      enable,
  output logic                      write,
  output logic [ID_W-1:0]           id,
  output logic [ADDR_W-1:0]         addr,
  output logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W-1:0]         rdata,
  input  logic                      ready
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [NUM_REQ-1:0] arb_req;
  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0] arb_oh;
  logic               arb_load;

  logic               nxt_write;
  logic [ID_W-1:0]    nxt_id;
  logic [ADDR_W-1:0]  nxt_addr;
  logic [DATA_W-1:0]  nxt_wdata;

  // During the owner's final ACCESS cycle its own req is masked so a
  // back-to-back re-arbitration can only pick a different requester.
  assign arb_req  = (state == ST_ACCESS) ? (req & ~gnt) : req;
  assign arb_load = arb_found && ((state == ST_IDLE) || ((state == ST_ACCESS) && ready));

  assign nxt_write = req_write[arb_idx];
  assign nxt_id    = req_id[int'(arb_idx) * ID_W +: ID_W];
  assign nxt_addr  = req_addr[int'(arb_idx) * ADDR_W +: ADDR_W];
  assign nxt_wdata = req_wdata[int'(arb_idx) * DATA_W +: DATA_W];

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (arb_req),
    .load   (arb_load),
    .found  (arb_found),
    .idx    (arb_idx),
    .onehot (arb_oh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      sel      <= 1'b0;
      enable   <= 1'b0;
      write    <= 1'b0;
      id       <= '0;
      addr     <= '0;
      wdata    <= '0;
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      rd_data  <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (arb_found) begin
            write <= nxt_write;
            id    <= nxt_id;
            addr  <= nxt_addr;
            wdata <= nxt_wdata;
            gnt   <= arb_oh;
            sel   <= 1'b1;
            state <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          enable   <= 1'b1;
          wait_cnt <= '0;
          state    <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (ready) begin
            done     <= gnt;
            wait_cnt <= '0;
            enable   <= 1'b0;
            if (!write) begin
              rd_data <= rdata;
            end
            if (arb_found) begin
              write <= nxt_write;
              id    <= nxt_id;
              addr  <= nxt_addr;
              wdata <= nxt_wdata;
              gnt   <= arb_oh;
              state <= ST_SETUP;
            end else begin
              sel   <= 1'b0;
              gnt   <= '0;
              state <= ST_IDLE;
            end
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            // TIMEOUT-th consecutive wait cycle: abort, leave rd_data untouched.
            done     <= gnt;
            err      <= 1'b1;
            sel      <= 1'b0;
            enable   <= 1'b0;
            gnt      <= '0;
            wait_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Self-checking bench: directed scenarios plus randomized request batches,
// predicted by a transaction-level round-robin / memory model.
module tb_apb_bus_arbiter;
  import apb_arb_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 6;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ID_W-1:0]   req_id;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic                      err;
  logic [DATA_W-1:0]         rd_data;
  logic                      sel;
  logic                      enable;
  logic                      write;
  logic [ID_W-1:0]           id;
  logic [ADDR_W-1:0]         addr;
  logic [DATA_W-1:0]         wdata;
  logic [DATA_W-1:0]         rdata;
  logic                      ready;

  apb_bus_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_write (req_write),
    .req_id    (req_id),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rd_data   (rd_data),
    .sel       (sel),
    .enable    (enable),
    .write     (write),
    .id        (id),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave environment: memory, and per-address wait-state count before ready.
  logic [DATA_W-1:0] mem      [256];
  logic [7:0]        wait_tab [256];
  int                acc_cnt;

  assign rdata = mem[addr];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5a);
    forever begin
      @(posedge clk);
      if (sel && enable && ready && write) mem[addr] = wdata;
    end
  end

  initial begin
    ready   = 1'b0;
    acc_cnt = 0;
    forever begin
      @(negedge clk);
      if (sel && enable) begin
        ready   = (acc_cnt >= int'(wait_tab[addr]));
        acc_cnt = acc_cnt + 1;
      end else begin
        ready   = 1'b0;
        acc_cnt = 0;
      end
    end
  end

  // Reference model state.
  logic [DATA_W-1:0] exp_mem [256];
  logic [DATA_W-1:0] exp_rd;
  int                model_ptr;

  logic              t_write [NUM_REQ];
  logic [ID_W-1:0]   t_id    [NUM_REQ];
  logic [ADDR_W-1:0] t_addr  [NUM_REQ];
  logic [DATA_W-1:0] t_wdata [NUM_REQ];

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int w);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [NUM_REQ-1:0] p, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (p[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic drive_fields(input int i);
    req_write[i]                 = t_write[i];
    req_id[i*ID_W +: ID_W]       = t_id[i];
    req_addr[i*ADDR_W +: ADDR_W] = t_addr[i];
    req_wdata[i*DATA_W +: DATA_W] = t_wdata[i];
  endtask

  task automatic check_done(input int w, input logic e);
    check("done", done, onehot(w));
    check("err", err, e);
    check("rd_data", rd_data, exp_rd);
  endtask

  // Called just after a negedge with the DUT idle: raises the requests in
  // 'set' and checks every cycle of the predicted grant sequence.
  task automatic run_batch(input logic [NUM_REQ-1:0] set, input bit drop_early);
    logic [NUM_REQ-1:0] pending;
    int  w, prev, nacc;
    bit  tmo, prev_tmo, first;
    for (int i = 0; i < NUM_REQ; i++) if (set[i]) drive_fields(i);
    req      = req | set;
    pending  = set;
    first    = 1'b1;
    prev     = 0;
    prev_tmo = 1'b0;
    while (pending != '0) begin
      w          = rr_pick(pending, model_ptr);
      model_ptr  = w;
      pending[w] = 1'b0;
      if (!first && prev_tmo) begin
        @(negedge clk);
        check_done(prev, 1'b1);
        check("tmo_idle_sel", sel, 1'b0);
        req[prev] = 1'b0;
      end
      @(negedge clk);
      if (!first && !prev_tmo) begin
        check_done(prev, 1'b0);
        req[prev] = 1'b0;
      end
      check("setup_sel", sel, 1'b1);
      check("setup_enable", enable, 1'b0);
      check("setup_gnt", gnt, onehot(w));
      check("setup_write", write, t_write[w]);
      check("setup_id", id, t_id[w]);
      check("setup_addr", addr, t_addr[w]);
      check("setup_wdata", wdata, t_wdata[w]);
      if (drop_early) req[w] = 1'b0;
      tmo  = (int'(wait_tab[t_addr[w]]) >= TIMEOUT);
      nacc = tmo ? TIMEOUT : int'(wait_tab[t_addr[w]]) + 1;
      for (int a = 0; a < nacc; a++) begin
        @(negedge clk);
        check("access_sel", sel, 1'b1);
        check("access_enable", enable, 1'b1);
        check("access_gnt", gnt, onehot(w));
        check("access_done", done, '0);
        check("access_addr", addr, t_addr[w]);
      end
      if (!tmo) begin
        if (t_write[w]) exp_mem[t_addr[w]] = t_wdata[w];
        else            exp_rd             = exp_mem[t_addr[w]];
      end
      prev     = w;
      prev_tmo = tmo;
      first    = 1'b0;
    end
    @(negedge clk);
    check_done(prev, prev_tmo);
    check("end_sel", sel, 1'b0);
    check("end_enable", enable, 1'b0);
    check("end_gnt", gnt, '0);
    req[prev] = 1'b0;
    @(negedge clk);
    check("idle_done", done, '0);
    check("idle_sel", sel, 1'b0);
    check("idle_addr_hold", addr, t_addr[prev]);
  endtask

  initial begin
    int mism;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req       = '0;
    req_write = '0;
    req_id    = '0;
    req_addr  = '0;
    req_wdata = '0;
    model_ptr = NUM_REQ - 1;
    exp_rd    = '0;
    for (int i = 0; i < 256; i++) begin
      exp_mem[i]  = 8'(i ^ 8'h5a);
      wait_tab[i] = 8'd0;
    end

    repeat (3) @(negedge clk);
    check("rst_sel", sel, 1'b0);
    check("rst_enable", enable, 1'b0);
    check("rst_write", write, 1'b0);
    check("rst_gnt", gnt, '0);
    check("rst_done", done, '0);
    check("rst_err", err, 1'b0);
    check("rst_id", id, '0);
    check("rst_addr", addr, '0);
    check("rst_wdata", wdata, '0);
    check("rst_rd_data", rd_data, '0);
    rst_n = 1'b1;

    // Single zero-wait write from requester 0.
    t_write[0] = 1'b1; t_id[0] = 2'd1; t_addr[0] = 8'd6; t_wdata[0] = 8'd5;
    wait_tab[6] = 8'd0;
    run_batch(3'b001, 1'b0);
    check("mem6_written", mem[6], 8'd5);

    // Read with TIMEOUT-1 wait states: ready on the last allowed cycle wins.
    t_write[1] = 1'b0; t_id[1] = 2'd2; t_addr[1] = 8'd6; t_wdata[1] = 8'hee;
    wait_tab[6] = 8'(TIMEOUT - 1);
    run_batch(3'b010, 1'b0);
    check("read_back_5", rd_data, 8'd5);

    // Contention, twice: order 0,1,0,1 with back-to-back transfers.
    t_write[0] = 1'b1; t_addr[0] = 8'h10; t_wdata[0] = 8'h77; wait_tab[8'h10] = 8'd0;
    t_write[1] = 1'b0; t_addr[1] = 8'h11;                      wait_tab[8'h11] = 8'd1;
    run_batch(3'b011, 1'b0);
    run_batch(3'b011, 1'b0);

    // Timeout on a hung read (rd_data must keep its value), then a slave that never answers.
    t_write[0] = 1'b0; t_addr[0] = 8'h20; wait_tab[8'h20] = 8'(TIMEOUT);
    run_batch(3'b001, 1'b0);
    t_write[2] = 1'b1; t_id[2] = 2'd3; t_addr[2] = 8'h21; t_wdata[2] = 8'h99;
    wait_tab[8'h21] = 8'd255;
    run_batch(3'b100, 1'b1);

    // Reset in the middle of ACCESS wait states.
    t_write[1] = 1'b0; t_id[1] = 2'd3; t_addr[1] = 8'h30; wait_tab[8'h30] = 8'd255;
    drive_fields(1);
    req[1] = 1'b1;
    @(negedge clk);
    check("pre_rst_sel", sel, 1'b1);
    repeat (3) @(negedge clk);
    check("pre_rst_enable", enable, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sel", sel, 1'b0);
    check("async_rst_enable", enable, 1'b0);
    check("async_rst_gnt", gnt, '0);
    check("async_rst_done", done, '0);
    model_ptr = NUM_REQ - 1;
    exp_rd    = '0;
    req[0]    = 1'b1;
    @(negedge clk);
    check("in_rst_done", done, '0);
    check("in_rst_rd_data", rd_data, '0);
    t_write[0] = 1'b1; t_addr[0] = 8'h31; t_wdata[0] = 8'h3c; wait_tab[8'h31] = 8'd2;
    t_write[1] = 1'b0; t_addr[1] = 8'h31;                     wait_tab[8'h31] = 8'd2;
    @(negedge clk);
    rst_n = 1'b1;
    run_batch(3'b011, 1'b0);

    // Randomized batches.
    for (int a = 0; a < 256; a++) wait_tab[a] = 8'($urandom_range(0, TIMEOUT + 1));
    for (int b = 0; b < 40; b++) begin
      logic [NUM_REQ-1:0] set;
      set = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        t_write[i] = 1'($urandom);
        t_id[i]    = ID_W'($urandom);
        t_addr[i]  = ADDR_W'($urandom);
        t_wdata[i] = DATA_W'($urandom);
      end
      run_batch(set, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    mism = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== exp_mem[a]) mism++;
    check("mem_image", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
